nand_cmd_sequencer: RTL

Host-side initiator for the NAND memory bus. Accepts one operation at a time (block erase, page program, page read) from the flash controller core. Emits the CLE/ALE/wEn/rEn phase sequence and address/data words on the shared DIO bus, and returns read data to the host. It sits between the controller datapath and the memory module, driving the interface that the memory module responds to.

---
 rtl/nand_pkg.sv | 31 +++
 rtl/nand_cmd_sequencer_if.sv | 39 +++
 rtl/nand_rd_capture.sv | 33 +++
 rtl/nand_cmd_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/nand_pkg.sv
// Shared types and constants for the NAND command sequencer.
package nand_pkg;

  localparam logic [1:0] OP_ERASE   = 2'd0;
  localparam logic [1:0] OP_PROGRAM = 2'd1;
  localparam logic [1:0] OP_READ    = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_RDRAIN,
    S_ERWAIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic ale;
    logic cle;
    logic wen;
    logic ren;
  } strobe_t;

  function automatic logic op_legal(input logic [1:0] op);
    return op != OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/nand_cmd_sequencer_if.sv
// Host request/stream signals and NAND bus pins of the command sequencer.
interface nand_cmd_sequencer_if #(
  parameter int unsigned DIOWidth = 16
);
  logic                req;
  logic [1:0]          op;
  logic [DIOWidth-1:0] addr;
  logic                ack;
  logic                busy;
  logic                done;
  logic                err;
  logic [DIOWidth-1:0] wr_data;
  logic                wr_valid;
  logic                wr_ready;
  logic [DIOWidth-1:0] rd_data;
  logic                rd_valid;
  logic                cEn;
  logic                ALE;
  logic                CLE;
  logic                wEn;
  logic                rEn;
  logic [DIOWidth-1:0] DIO_out;
  logic                DIO_oe;
  logic [DIOWidth-1:0] DIO_in;

  // Sequencer side.
  modport master (
    input  req, op, addr, wr_data, wr_valid, DIO_in,
    output ack, busy, done, err, wr_ready, rd_data, rd_valid,
    output cEn, ALE, CLE, wEn, rEn, DIO_out, DIO_oe
  );

  // Host controller plus memory responder side.
  modport slave (
    output req, op, addr, wr_data, wr_valid, DIO_in,
    input  ack, busy, done, err, wr_ready, rd_data, rd_valid,
    input  cEn, ALE, CLE, wEn, rEn, DIO_out, DIO_oe
  );
endinterface

// File: rtl/nand_rd_capture.sv
// Delays the rEn-cycle flag by RdLat cycles and registers DIO_in into rd_data.
module nand_rd_capture #(
  parameter int unsigned DIOWidth = 16,
  parameter int unsigned RdLat    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ren,
  input  logic [DIOWidth-1:0] dio_in,
  output logic                rd_valid,
  output logic [DIOWidth-1:0] rd_data
);

  logic [RdLat-1:0] pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      pend[0] <= ren;
      for (int unsigned i = 1; i < RdLat; i++) begin
        pend[i] <= pend[i-1];
      end
      rd_valid <= pend[RdLat-1];
      if (pend[RdLat-1]) begin
        rd_data <= dio_in;
      end
    end
  end

endmodule

// File: rtl/nand_cmd_sequencer.sv
// NAND bus initiator: sequences CLE/ALE/wEn/rEn phases for erase, program and read.
module nand_cmd_sequencer
  import nand_pkg::*;
#(
  parameter int unsigned DIOWidth    = 16,
  parameter int unsigned PageWords   = 2048,
  parameter int unsigned EraseCycles = 2,
  parameter int unsigned RdLat       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nand_cmd_sequencer_if.master bus
);

  localparam int unsigned CntW = $clog2(PageWords) + 1;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [DIOWidth-1:0] addr_q, addr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  strobe_t             strb_q, strb_d;
  logic [DIOWidth-1:0] dio_q, dio_d;
  logic                oe_q, oe_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_ready_q, wr_ready_d;
  logic                fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      strb_q     <= '0;
      dio_q      <= '0;
      oe_q       <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      strb_q     <= strb_d;
      dio_q      <= dio_d;
      oe_q       <= oe_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    strb_d     = '0;
    dio_d      = '0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wr_ready_d = 1'b0;
    fire       = bus.wr_valid && wr_ready_q;

    // Every output is registered, so each branch computes the values for the
    // cycle spent in state_d rather than the current one.
    unique case (state_q)
      S_IDLE: begin
        if (bus.req && !ack_q) begin
          ack_d = 1'b1;
          if (op_legal(bus.op)) begin
            op_d       = bus.op;
            addr_d     = bus.addr;
            state_d    = S_CMD;
            busy_d     = 1'b1;
            strb_d.cle = 1'b1;
            dio_d      = DIOWidth'(bus.op);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CMD: begin
        state_d    = S_ADDR;
        strb_d.ale = 1'b1;
        dio_d      = addr_q;
      end
      S_ADDR: begin
        cnt_d = '0;
        case (op_q)
          OP_ERASE:   state_d = S_ERWAIT;
          OP_PROGRAM: begin
            state_d    = S_WDATA;
            wr_ready_d = 1'b1;
          end
          default: begin
            state_d    = S_RDATA;
            strb_d.ren = 1'b1;
          end
        endcase
      end
      S_ERWAIT: begin
        if (cnt_q == CntW'(EraseCycles - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_WDATA: begin
        // A word accepted on this edge is driven with wEn in the next cycle,
        // so the page finishes one cycle after the final handshake.
        if (cnt_q == CntW'(PageWords)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          wr_ready_d = 1'b1;
          if (fire) begin
            strb_d.wen = 1'b1;
            dio_d      = bus.wr_data;
            cnt_d      = cnt_q + CntW'(1);
            if (cnt_q == CntW'(PageWords - 1)) begin
              wr_ready_d = 1'b0;
            end
          end
        end
      end
      S_RDATA: begin
        if (cnt_q == CntW'(PageWords - 1)) begin
          state_d = S_RDRAIN;
          cnt_d   = '0;
        end else begin
          strb_d.ren = 1'b1;
          cnt_d      = cnt_q + CntW'(1);
        end
      end
      S_RDRAIN: begin
        if (cnt_q == CntW'(RdLat - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase

    oe_d = strb_d.ale | strb_d.cle | strb_d.wen;
  end

  nand_rd_capture #(
    .DIOWidth(DIOWidth),
    .RdLat   (RdLat)
  ) u_rd_capture (
    .clk     (clk),
    .rst_n   (rst_n),
    .ren     (strb_q.ren),
    .dio_in  (bus.DIO_in),
    .rd_valid(bus.rd_valid),
    .rd_data (bus.rd_data)
  );

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wr_ready = wr_ready_q;
  assign bus.cEn      = busy_q;
  assign bus.ALE      = strb_q.ale;
  assign bus.CLE      = strb_q.cle;
  assign bus.wEn      = strb_q.wen;
  assign bus.rEn      = strb_q.ren;
  assign bus.DIO_out  = dio_q;
  assign bus.DIO_oe   = oe_q;

endmodule
